// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types and constants for the Y86-64 memory path
package y86_mem_pkg;

    localparam int QUAD_W     = 64;
    localparam int QUAD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_D,
        OWN_I
    } owner_t;

    // Instruction codes whose memory stage drives the D port
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    function automatic logic icode_reads_dmem(input logic [3:0] icode);
        return (icode == ICODE_MRMOVQ) || (icode == ICODE_RET) || (icode == ICODE_POPQ);
    endfunction

    function automatic logic icode_writes_dmem(input logic [3:0] icode);
        return (icode == ICODE_RMMOVQ) || (icode == ICODE_CALL) || (icode == ICODE_PUSHQ);
    endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// rtl/dmem_addr_check.sv - combinational quad-access range check
module dmem_addr_check #(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);
    import y86_mem_pkg::*;

    // Last byte address at which a full quad still fits inside the array
    localparam logic [ADDR_W-1:0] LAST_QUAD = ADDR_W'(MEM_BYTES - QUAD_BYTES);

    assign in_range = (addr <= LAST_QUAD);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - D/I port arbiter for the shared Y86-64 memory (optional stats: DMEM_ARB_STATS_EN)
module dmem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MEM_BYTES    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_error
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_d_cnt,
    output logic [31:0]       stat_i_cnt,
    output logic [31:0]       stat_conflict_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state;
    owner_t            owner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starved;
    logic              pick_d;
    logic              pick_i;
    logic [ADDR_W-1:0] sel_addr;
    logic              addr_ok;
    logic              we_lat;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Arbitration: D has priority unless I has been passed over STARVE_LIMIT times
    always_comb begin
        starved  = (starve_cnt == STARVE_MAX);
        pick_i   = i_req && (!d_req || starved);
        pick_d   = d_req && !pick_i;
        sel_addr = pick_i ? i_addr : d_addr;
    end

    // Checking the winner's address here is the same as checking the latched copy,
    // and lets the grant edge decide between BUSY and an immediate error response
    dmem_addr_check #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_check (
        .addr     (sel_addr),
        .in_range (addr_ok)
    );

    // Transaction FSM: grant, memory access, response; all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_D;
            starve_cnt <= '0;
            d_gnt      <= 1'b0;
            i_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rdata    <= '0;
            i_rdata    <= '0;
            d_err      <= 1'b0;
            i_err      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_lat     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            d_gnt    <= 1'b0;
            i_gnt    <= 1'b0;
            d_rvalid <= 1'b0;
            i_rvalid <= 1'b0;
            d_err    <= 1'b0;
            i_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d || pick_i) begin
                        owner      <= pick_i ? OWN_I : OWN_D;
                        d_gnt      <= pick_d;
                        i_gnt      <= pick_i;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= pick_d ? d_wdata : '0;
                        we_lat     <= pick_d && d_we;
                        mem_we     <= pick_d && d_we && addr_ok;
                        mem_req    <= addr_ok;
                        resp_rdata <= '0;
                        resp_err   <= !addr_ok;
                        state      <= addr_ok ? BUSY : RESP;
                        if (pick_i) begin
                            starve_cnt <= '0;
                        end else if (i_req && !starved) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_rdata <= we_lat ? '0 : mem_rdata;
                        resp_err   <= mem_error;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (owner == OWN_D) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= resp_rdata;
                        d_err    <= resp_err;
                    end else begin
                        i_rvalid <= 1'b1;
                        i_rdata  <= resp_rdata;
                        i_err    <= resp_err;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Grant and contention counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_d_cnt        <= '0;
            stat_i_cnt        <= '0;
            stat_conflict_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                stat_d_cnt <= stat_d_cnt + 32'd1;
            end
            if (pick_i) begin
                stat_i_cnt <= stat_i_cnt + 32'd1;
            end
            if (d_req && i_req) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
